// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the 16-bit XNOR Fibonacci LFSR used by
// the stream generator and the receive-side checker.
//   LFSR_W      register width (bits numbered LFSR_W..1)
//   TAP_*       feedback tap positions 16, 15, 13, 4
//   lfsr_next() XNOR feedback bit shifted in at position 1
//   state_e     checker FSM states
package lfsr_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned TAP_A  = 16;
  localparam int unsigned TAP_B  = 15;
  localparam int unsigned TAP_C  = 13;
  localparam int unsigned TAP_D  = 4;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_e;

  function automatic logic lfsr_next(input logic [LFSR_W:1] s);
    return ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]);
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// lfsr_gen: transmit-side 16-bit XNOR Fibonacci LFSR bit generator.
// Ports:
//   clock    system clock, rising edge
//   reset_l  asynchronous active-low reset (register cleared to 0)
//   en       advance the register by one bit
//   q        current stream bit (the bit shifted in on the next enabled edge)
module lfsr_gen
  import lfsr_pkg::*;
(
  input  logic clock,
  input  logic reset_l,
  input  logic en,
  output logic q
);

  logic [LFSR_W:1] s_q;

  assign q = lfsr_next(s_q);

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      s_q <= '0;
    end else if (en) begin
      s_q <= {s_q[LFSR_W-1:1], q};
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for the 16-bit XNOR LFSR stream.
// Loads received bits (HUNT), verifies its own prediction against the line
// (VERIFY), then flywheels on the prediction and flags mismatches (LOCKED).
// Ports:
//   clock      system clock, rising edge
//   reset_l    asynchronous active-low reset
//   en         d is a valid stream bit this cycle
//   d          received stream bit
//   clr        synchronous clear of err_count
//   locked     checker is in LOCKED
//   err        one-cycle pulse: previous valid bit mismatched while LOCKED
//   err_count  saturating count of errors seen while LOCKED
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 32,
  parameter int unsigned WINDOW     = 64,
  parameter int unsigned LOSS_ERRS  = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             en,
  input  logic             d,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned FILL_W = $clog2(LFSR_W);
  localparam int unsigned WIN_W  = $clog2(WINDOW);
  localparam int unsigned WE_W   = $clog2(LOSS_ERRS + 1);

  state_e           state_q, state_d;
  logic [LFSR_W:1]  r_q, r_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WE_W-1:0]  werr_q, werr_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] ecnt_q, ecnt_d;

  logic            pred;
  logic            mism;
  logic [LFSR_W:1] shifted;
  logic [WE_W-1:0] werr_inc;
  logic            count_err;

  assign pred     = lfsr_next(r_q);
  assign mism     = d != pred;
  assign shifted  = {r_q[LFSR_W-1:1], d};
  assign werr_inc = werr_q + WE_W'(mism);

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    fill_d    = fill_q;
    match_d   = match_q;
    win_d     = win_q;
    werr_d    = werr_q;
    err_d     = 1'b0;
    count_err = 1'b0;

    if (en) begin
      unique case (state_q)
        HUNT: begin
          r_d = shifted;
          if (fill_q == FILL_W'(LFSR_W - 1)) begin
            state_d = VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        VERIFY: begin
          r_d = shifted;
          if (mism) begin
            match_d = '0;
          end else if (match_q == 8'(LOCK_COUNT - 1)) begin
            // All-ones is the XNOR lock-up state: never lock onto it.
            match_d = '0;
            if (!(&shifted)) begin
              state_d = LOCKED;
              win_d   = '0;
              werr_d  = '0;
            end
          end else begin
            match_d = match_q + 8'd1;
          end
        end
        LOCKED: begin
          r_d = {r_q[LFSR_W-1:1], pred};
          if (mism) begin
            err_d     = 1'b1;
            count_err = 1'b1;
          end
          // An error on the wrap bit is judged against the old window.
          if (werr_inc == WE_W'(LOSS_ERRS)) begin
            state_d = HUNT;
            fill_d  = '0;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WIN_W'(WINDOW - 1)) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + WIN_W'(1);
            werr_d = werr_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clr) begin
      ecnt_d = count_err ? ERR_W'(1) : '0;
    end else if (count_err && (ecnt_q != '1)) begin
      ecnt_d = ecnt_q + ERR_W'(1);
    end else begin
      ecnt_d = ecnt_q;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= HUNT;
      r_q      <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      win_q    <= win_d;
      werr_q   <= werr_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = ecnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

  logic clock, reset_l, en, d, clr;
  logic locked, err, locked4, err4, gen_q;
  logic [15:0] err_count;
  logic [3:0]  err_count4;

  lfsr_checker dut (
    .clock(clock), .reset_l(reset_l), .en(en), .d(d), .clr(clr),
    .locked(locked), .err(err), .err_count(err_count)
  );

  lfsr_checker #(.ERR_W(4)) dut4 (
    .clock(clock), .reset_l(reset_l), .en(en), .d(d), .clr(clr),
    .locked(locked4), .err(err4), .err_count(err_count4)
  );

  lfsr_gen gen (.clock(clock), .reset_l(reset_l), .en(en), .q(gen_q));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  logic [16:1] gs;      // reference stream generator
  logic gq;
  assign gq = ~(gs[16] ^ gs[15] ^ gs[13] ^ gs[4]);

  bit hist[$];          // checker register, hist[0] = newest bit
  bit stream[$];        // valid bits seen since reset
  int mode;             // 0 loading, 1 verifying, 2 locked
  int fill, match, wpos, werr, vcnt;
  int unsigned ec16, ec4;
  logic exp_locked, exp_err;

  function automatic bit predict();
    return !(hist[15] ^ hist[14] ^ hist[12] ^ hist[3]);
  endfunction

  function automatic bit all_ones();
    for (int i = 0; i < 16; i++) if (!hist[i]) return 0;
    return 1;
  endfunction

  task automatic push_bit(input bit b);
    hist.push_front(b);
    if (hist.size() > 16) void'(hist.pop_back());
  endtask

  always @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      gs = '0;
      hist.delete();
      for (int i = 0; i < 16; i++) hist.push_back(1'b0);
      stream.delete();
      mode = 0; fill = 0; match = 0; wpos = 0; werr = 0; vcnt = 0;
      ec16 = 0; ec4 = 0; exp_locked = 0; exp_err = 0;
    end else begin
      bit p, e;
      e = 0;
      if (en) begin
        p = predict();
        vcnt++;
        stream.push_back(d);
        gs = {gs[15:1], gq};
        if (mode == 0) begin
          push_bit(d);
          fill++;
          if (fill == 16) begin mode = 1; match = 0; end
        end else if (mode == 1) begin
          push_bit(d);
          if (d == p) begin
            match++;
            if (match == 32) begin
              match = 0;
              if (!all_ones()) begin mode = 2; wpos = 0; werr = 0; end
            end
          end else begin
            match = 0;
          end
        end else begin
          push_bit(p);
          if (d != p) begin
            e = 1;
            werr++;
            if (ec16 < 65535) ec16++;
            if (ec4 < 15) ec4++;
          end
          if (werr == 4) begin
            mode = 0; fill = 0; match = 0; wpos = 0; werr = 0;
          end else if (wpos == 63) begin
            wpos = 0; werr = 0;
          end else begin
            wpos++;
          end
        end
      end
      if (clr) begin
        ec16 = e; ec4 = e;
      end
      exp_err = e;
      exp_locked = (mode == 2);
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clock) begin
    if (reset_l && chk_on) begin
      chk("locked", locked, exp_locked);
      chk("err", err, exp_err);
      chk("err_count", err_count, ec16);
      chk("locked4", locked4, exp_locked);
      chk("err4", err4, exp_err);
      chk("err_count4", err_count4, ec4);
      chk("gen_q", gen_q, gq);
    end
  end

  // ---------------- stimulus ----------------
  bit lk_seen;
  int nerr;

  task automatic drive(input bit e, input bit flip, input bit c, input int dm);
    en = e;
    clr = c;
    if (!e) d = 1'($urandom);
    else if (dm == 0) d = gq ^ flip;
    else d = (dm == 1);
  endtask

  task automatic tick(input bit e, input bit flip, input bit c, input int dm);
    @(negedge clock);
    if (locked) lk_seen = 1;
    if (err) nerr++;
    drive(e, flip, c, dm);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_l = 0; en = 0; clr = 0; d = 0;
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_count4", err_count4, 0);
    @(negedge clock);
    reset_l = 1;
    lk_seen = 0;
    nerr = 0;
  endtask

  task automatic wait_lock(input int pct, output int at);
    at = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (locked) begin at = vcnt; break; end
      drive($urandom_range(0, 99) < pct, 0, 0, 0);
    end
    en = 0; clr = 0;
    if (at < 0) chk("lock_timeout", 0, 1);
  endtask

  initial begin
    int at, base;
    logic [4:0] head;
    reset_l = 0; en = 0; d = 0; clr = 0;
    lk_seen = 0; nerr = 0;
    #2;
    do_reset();
    chk_on = 1;
    chk("gen_first_bit", gq, 1);

    // 1: clean stream, lock after bit 48, no errors
    wait_lock(100, at);
    chk("lock_at", at, 48);
    head = {stream[0], stream[1], stream[2], stream[3], stream[4]};
    chk("stream_head", head, 5'b11110);
    for (int i = 0; i < 10000; i++) tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("clean_pulses", nerr, 0);
    chk("clean_err_count", err_count, 0);
    chk("clean_locked", locked, 1);

    // 2: single line error
    nerr = 0;
    tick(1, 1, 0, 0);
    for (int i = 0; i < 1000; i++) tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("single_pulses", nerr, 1);
    chk("single_err_count", err_count, 1);
    chk("single_locked", locked, 1);

    // 3a: four errors in a window force loss, relock 48 bits later
    do_reset();
    wait_lock(100, at);
    for (int i = 0; i < 10; i++) tick(1, 0, 0, 0);
    for (int k = 0; k < 16; k++) tick(1, (k % 5) == 0, 0, 0);
    @(negedge clock);
    chk("loss_locked", locked, 0);
    chk("loss_err_count", err_count, 4);
    base = vcnt;
    drive(0, 0, 0, 0);
    wait_lock(100, at);
    chk("relock_bits", at - base, 48);

    // 3b: three errors per window either side of a wrap
    do_reset();
    wait_lock(100, at);
    for (int j = 0; j < 300; j++)
      tick(1, (j == 50) || (j == 55) || (j == 63) || (j == 64) || (j == 70) || (j == 80), 0, 0);
    tick(0, 0, 0, 0);
    chk("wrap_locked", locked, 1);
    chk("wrap_err_count", err_count, 6);

    // 4: constant streams never lock
    do_reset();
    for (int i = 0; i < 500; i++) tick(1, 0, 0, 1);
    tick(0, 0, 0, 0);
    chk("ones_no_lock", lk_seen, 0);
    do_reset();
    for (int i = 0; i < 500; i++) tick(1, 0, 0, 2);
    tick(0, 0, 0, 0);
    chk("zeros_no_lock", lk_seen, 0);

    // 5: gapped enable
    do_reset();
    wait_lock(30, at);
    chk("gapped_lock_at", at, 48);
    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 2, 0, 0);

    // 6: saturation, clr interplay, reset while locked
    do_reset();
    wait_lock(100, at);
    for (int e = 0; e < 20; e++) begin
      tick(1, 1, 0, 0);
      for (int i = 0; i < 31; i++) tick(1, 0, 0, 0);
    end
    tick(0, 0, 0, 0);
    chk("sat_err_count4", err_count4, 15);
    chk("sat_err_count", err_count, 20);
    chk("sat_locked", locked, 1);
    tick(1, 1, 1, 0);
    tick(0, 0, 0, 0);
    chk("clr_err_count", err_count, 1);
    chk("clr_err_count4", err_count4, 1);
    tick(1, 0, 1, 0);
    tick(0, 0, 0, 0);
    chk("clr_only", err_count, 0);
    for (int e = 0; e < 3; e++) begin
      tick(1, 1, 0, 0);
      for (int i = 0; i < 40; i++) tick(1, 0, 0, 0);
    end
    tick(0, 0, 0, 0);
    chk("pre_reset_count", err_count, 3);
    do_reset();
    for (int i = 0; i < 20; i++) tick($urandom_range(0, 1), 0, 0, 0);
    tick(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
